touch_event_gen: RTL and testbench
==================================

// Module: touch_event_gen
// PURPOSE
// - Producer side of the game FSM touch interface: turns raw touch samples from the panel driver into
//   debounced tap events.
// - Each qualified tap drives exactly one cycle of move_on, together with tp_x_coord/tp_y_coord.
// - Sits between the touch-controller driver and the overall game FSM.
// - Rejects contact bounce, coordinate jitter, off-screen samples and a stalled driver.
// PARAMETERS
// DEBOUNCE_CYCLES  500000  stable-touch time before a tap fires; also the release hold time (10 ms @ 50 MHz)
// STALE_CYCLES     5000000 cycles with no s_valid while pressed before a forced release (100 ms)
// JITTER           8       max |dx| and max |dy| (pixels) from the anchor tolerated during debounce
// X_MAX            799     largest legal x coordinate
// Y_MAX            479     largest legal y coordinate
// PORTS
// clk          in   1   system clock
// rst          in   1   asynchronous, active-high reset
// s_valid      in   1   one-cycle strobe: new sample on s_touch/s_x/s_y (no backpressure)
// s_touch      in   1   sample reports finger down
// s_x          in   16  sample x
// s_y          in   16  sample y
// move_on      out  1   one-cycle tap pulse
// tp_x_coord   out  16  tap x; held until the next tap
// tp_y_coord   out  16  tap y; held until the next tap
// touching     out  1   high while in PRESSED or RELEASE
// BEHAVIOUR
// - Reset (async, rst=1): state IDLE; move_on=0, touching=0, tp_x_coord=0, tp_y_coord=0; counters=0.
// - hit = s_valid & s_touch & s_x<=X_MAX & s_y<=Y_MAX.
// - miss = s_valid & ~hit. An off-screen touch counts as a miss.
// - All outputs are registered. move_on defaults to 0 every cycle.
// IDLE:
// - On hit: anchor<=(s_x,s_y), cnt<=0, go to DEBOUNCE.
// DEBOUNCE:
// - cnt increments every cycle.
// - miss -> IDLE.
// - hit outside JITTER of the anchor (|dx|>JITTER or |dy|>JITTER) -> re-anchor to the new sample, cnt<=0.
// - hit within JITTER: anchor is not changed.
// - When cnt==DEBOUNCE_CYCLES-1 with no abort/re-anchor that cycle: tp_*<=anchor, move_on<=1, go to PRESSED.
// - Latency: first hit at edge k, so move_on is high from edge k+DEBOUNCE_CYCLES to k+DEBOUNCE_CYCLES+1.
//   Coordinates change on the same edge that move_on rises.
// - A sample arriving in the terminal cycle wins: a miss aborts, a far hit re-anchors, and no pulse is produced.
// PRESSED:
// - No further pulses; there is no auto-repeat.
// - Any s_valid clears the stale counter.
// - miss -> RELEASE, cnt<=0.
// - Stale counter reaches STALE_CYCLES-1 -> IDLE (touching drops).
// RELEASE:
// - cnt increments every cycle.
// - hit -> PRESSED with no new pulse (release bounce).
// - cnt==DEBOUNCE_CYCLES-1 -> IDLE.
// Arithmetic and reset:
// - Deltas are computed as 17-bit signed differences, then taken as absolute value.
// - Counters are sized $clog2(max(DEBOUNCE_CYCLES,STALE_CYCLES)) bits and saturate; they never wrap.
// - Reset mid-operation drops any pending tap; tp_* return to 0.
// - The (0,0) reset coordinate lies outside every on-screen button.
// STRUCTURE
// - Shared header: X_MAX/Y_MAX screen dimensions, the state encoding (IDLE/DEBOUNCE/PRESSED/RELEASE),
//   and the default timing constants. Both this block and the game FSM use them.
// - One sub-module, touch_jitter_cmp: combinational, (ax,ay,bx,by) -> near = |dx|<=JITTER & |dy|<=JITTER.
// - Top level: 2-process FSM, one shared debounce/release counter, one stale counter.
// TESTING (bench params: DEBOUNCE_CYCLES=4, STALE_CYCLES=16, JITTER=8)
// 1. rst=1 mid-DEBOUNCE with samples still streaming -> all outputs 0 immediately; no pulse after rst=0
//    until 4 fresh hits.
// 2. hit (110,110) on every cycle from edge k -> single move_on at edge k+4, tp=(110,110), touching=1.
//    Then misses for 4 cycles -> touching=0.
// 3. Bounce: hits for 2 cycles, 1 miss, hits -> no pulse until 4 consecutive hit cycles after the miss.
// 4. Jitter: hit (110,110) then (115,104) -> pulse with tp=(110,110).
//    Repeat with (130,110) as the second sample -> re-anchor, pulse 4 cycles later with tp=(130,110).
// 5. Hold hit 100 cycles, then a miss, a hit 2 cycles later, then misses -> exactly one move_on total.
//    touching stays 1 until the final 4 misses.
// 6. Off-screen hit (900,100) for 10 cycles -> no pulse.
//    In PRESSED, s_valid held 0 for 16 cycles -> touching=0, state IDLE.

Source files
------------

// File: rtl/touch_event_gen_pkg.sv
// Shared screen geometry, tap FSM state encoding and default timing for the
// touch front end and the game FSM.
package touch_event_gen_pkg;

  localparam int X_MAX = 799;
  localparam int Y_MAX = 479;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_STALE_CYCLES    = 5000000;
  localparam int DEF_JITTER          = 8;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } touch_state_t;

  // Width of a counter that must reach the larger of the two timing limits.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/touch_event_gen_if.sv
// Sample stream from the panel driver plus the tap events handed to the game FSM.
interface touch_event_gen_if;

  logic        s_valid;
  logic        s_touch;
  logic [15:0] s_x;
  logic [15:0] s_y;
  logic        move_on;
  logic [15:0] tp_x_coord;
  logic [15:0] tp_y_coord;
  logic        touching;

  modport master (
    output s_valid, s_touch, s_x, s_y,
    input  move_on, tp_x_coord, tp_y_coord, touching
  );

  modport slave (
    input  s_valid, s_touch, s_x, s_y,
    output move_on, tp_x_coord, tp_y_coord, touching
  );

endinterface

// File: rtl/touch_jitter_cmp.sv
// Combinational check that two points lie within JITTER pixels on each axis.
module touch_jitter_cmp #(
  parameter int JITTER = 8
) (
  input  logic [15:0] ax,
  input  logic [15:0] ay,
  input  logic [15:0] bx,
  input  logic [15:0] by,
  output logic        near
);

  logic signed [16:0] dx;
  logic signed [16:0] dy;
  logic        [16:0] adx;
  logic        [16:0] ady;

  always_comb begin
    dx   = $signed({1'b0, bx}) - $signed({1'b0, ax});
    dy   = $signed({1'b0, by}) - $signed({1'b0, ay});
    adx  = dx[16] ? unsigned'(-dx) : unsigned'(dx);
    ady  = dy[16] ? unsigned'(-dy) : unsigned'(dy);
    near = (adx <= 17'(JITTER)) && (ady <= 17'(JITTER));
  end

endmodule

// File: rtl/touch_event_gen.sv
// Turns raw touch samples into debounced one-cycle tap events with coordinates,
// filtering contact bounce, jitter, off-screen samples and a stalled driver.
module touch_event_gen
  import touch_event_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int STALE_CYCLES    = DEF_STALE_CYCLES,
  parameter int JITTER          = DEF_JITTER
) (
  input  logic              clk,
  input  logic              rst,
  touch_event_gen_if.slave  bus
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, STALE_CYCLES);

  touch_state_t  state;
  logic [15:0]   anchor_x;
  logic [15:0]   anchor_y;
  logic [CW-1:0] cnt;
  logic [CW-1:0] stale_cnt;
  logic          hit;
  logic          miss;
  logic          near;

  assign hit  = bus.s_valid & bus.s_touch &
                (bus.s_x <= 16'(X_MAX)) & (bus.s_y <= 16'(Y_MAX));
  assign miss = bus.s_valid & ~hit;

  touch_jitter_cmp #(.JITTER(JITTER)) u_jitter (
    .ax   (anchor_x),
    .ay   (anchor_y),
    .bx   (bus.s_x),
    .by   (bus.s_y),
    .near (near)
  );

  // A sample in the terminal debounce cycle takes priority over firing the tap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      anchor_x       <= '0;
      anchor_y       <= '0;
      cnt            <= '0;
      stale_cnt      <= '0;
      bus.move_on    <= 1'b0;
      bus.touching   <= 1'b0;
      bus.tp_x_coord <= '0;
      bus.tp_y_coord <= '0;
    end else begin
      bus.move_on <= 1'b0;
      case (state)
        IDLE: begin
          if (hit) begin
            anchor_x <= bus.s_x;
            anchor_y <= bus.s_y;
            cnt      <= '0;
            state    <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (miss) begin
            state <= IDLE;
          end else if (hit && !near) begin
            anchor_x <= bus.s_x;
            anchor_y <= bus.s_y;
            cnt      <= '0;
          end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            bus.tp_x_coord <= anchor_x;
            bus.tp_y_coord <= anchor_y;
            bus.move_on    <= 1'b1;
            bus.touching   <= 1'b1;
            stale_cnt      <= '0;
            state          <= PRESSED;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (miss) begin
            cnt   <= '0;
            state <= RELEASE;
          end else if (bus.s_valid) begin
            stale_cnt <= '0;
          end else if (stale_cnt == CW'(STALE_CYCLES - 1)) begin
            bus.touching <= 1'b0;
            state        <= IDLE;
          end else if (stale_cnt != '1) begin
            stale_cnt <= stale_cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (hit) begin
            stale_cnt <= '0;
            state     <= PRESSED;
          end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            bus.touching <= 1'b0;
            state        <= IDLE;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          bus.touching <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_touch_event_gen.sv
// Directed and randomized checks of touch_event_gen against a timestamp-based
// reference model of the tap rules.
module tb_touch_event_gen;

  localparam int DEB   = 4;
  localparam int STALE = 16;
  localparam int JIT   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passed = 0;
  int   pulses = 0;
  int   p0;

  touch_event_gen_if bus ();

  touch_event_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .STALE_CYCLES    (STALE),
    .JITTER          (JIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference model: tracks the edge at which each phase began and fires on elapsed time.
  int m_mode = 0;
  int cyc = 0, anc_edge = 0, ax = 0, ay = 0, last_valid = 0, rel_edge = 0;
  int m_tx = 0, m_ty = 0;
  bit m_move = 1'b0, m_touch = 1'b0;

  always @(posedge clk or posedge rst) begin
    bit h, ms, far;
    int x, y;
    if (rst) begin
      m_mode = 0; m_move = 1'b0; m_touch = 1'b0; m_tx = 0; m_ty = 0;
    end else begin
      cyc++;
      x   = int'(bus.s_x);
      y   = int'(bus.s_y);
      h   = bus.s_valid && bus.s_touch && x <= 799 && y <= 479;
      ms  = bus.s_valid && !h;
      far = ((x > ax) ? x - ax : ax - x) > JIT || ((y > ay) ? y - ay : ay - y) > JIT;
      m_move = 1'b0;
      if (m_mode == 0) begin
        if (h) begin m_mode = 1; anc_edge = cyc; ax = x; ay = y; end
      end else if (m_mode == 1) begin
        if (ms) m_mode = 0;
        else if (h && far) begin anc_edge = cyc; ax = x; ay = y; end
        else if (cyc - anc_edge == DEB) begin
          m_move = 1'b1; m_tx = ax; m_ty = ay; m_mode = 2; last_valid = cyc;
        end
      end else if (m_mode == 2) begin
        if (bus.s_valid) last_valid = cyc;
        if (ms) begin m_mode = 3; rel_edge = cyc; end
        else if (cyc - last_valid == STALE) m_mode = 0;
      end else begin
        if (h) begin m_mode = 2; last_valid = cyc; end
        else if (cyc - rel_edge == DEB) m_mode = 0;
      end
      m_touch = (m_mode == 2 || m_mode == 3);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    else
      passed++;
  endtask

  always @(negedge clk) begin
    checkOutput("move_on",    32'(bus.move_on),    32'(m_move));
    checkOutput("touching",   32'(bus.touching),   32'(m_touch));
    checkOutput("tp_x_coord", 32'(bus.tp_x_coord), m_tx);
    checkOutput("tp_y_coord", 32'(bus.tp_y_coord), m_ty);
    if (bus.move_on === 1'b1) pulses++;
  end

  task automatic applyStimulus(input bit v, input bit t, input int x, input int y, input int n);
    repeat (n) begin
      @(negedge clk);
      bus.s_valid = v;
      bus.s_touch = t;
      bus.s_x     = 16'(x);
      bus.s_y     = 16'(y);
    end
  endtask

  task automatic releaseFinger();
    applyStimulus(1'b1, 1'b0, 0, 0, 2);
    applyStimulus(1'b0, 1'b0, 0, 0, 6);
  endtask

  initial begin
    int pat, cxr, cyr;
    bus.s_valid = 1'b0; bus.s_touch = 1'b0; bus.s_x = '0; bus.s_y = '0;
    applyStimulus(1'b0, 1'b0, 0, 0, 3);
    #1;
    checkOutput("reset_touching", 32'(bus.touching), 0);
    checkOutput("reset_tp_x", 32'(bus.tp_x_coord), 0);
    @(negedge clk);
    rst = 1'b0;

    // Steady tap, then release
    p0 = pulses;
    applyStimulus(1'b1, 1'b1, 110, 110, 6);
    #1;
    checkOutput("tap_pulses", 32'(pulses - p0), 1);
    checkOutput("tap_tp_x", 32'(bus.tp_x_coord), 110);
    checkOutput("tap_tp_y", 32'(bus.tp_y_coord), 110);
    checkOutput("tap_touching", 32'(bus.touching), 1);
    applyStimulus(1'b1, 1'b0, 0, 0, 4);
    applyStimulus(1'b0, 1'b0, 0, 0, 3);
    #1;
    checkOutput("tap_released", 32'(bus.touching), 0);

    // Reset in the middle of a debounce with samples still streaming
    applyStimulus(1'b1, 1'b1, 200, 200, 2);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_move_on", 32'(bus.move_on), 0);
    checkOutput("rst_touching", 32'(bus.touching), 0);
    checkOutput("rst_tp_x", 32'(bus.tp_x_coord), 0);
    p0 = pulses;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b1, 200, 200, 4);
    #1;
    checkOutput("rst_no_early_pulse", 32'(pulses - p0), 0);
    applyStimulus(1'b1, 1'b1, 200, 200, 1);
    #1;
    checkOutput("rst_fresh_pulse", 32'(pulses - p0), 1);
    releaseFinger();

    // Contact bounce restarts the debounce
    p0 = pulses;
    applyStimulus(1'b1, 1'b1, 300, 200, 2);
    applyStimulus(1'b1, 1'b0, 300, 200, 1);
    applyStimulus(1'b1, 1'b1, 300, 200, 3);
    #1;
    checkOutput("bounce_no_pulse", 32'(pulses - p0), 0);
    applyStimulus(1'b1, 1'b1, 300, 200, 3);
    #1;
    checkOutput("bounce_pulse", 32'(pulses - p0), 1);
    releaseFinger();

    // Small jitter keeps the anchor, a large step re-anchors
    p0 = pulses;
    applyStimulus(1'b1, 1'b1, 110, 110, 1);
    applyStimulus(1'b1, 1'b1, 115, 104, 1);
    applyStimulus(1'b0, 1'b0, 0, 0, 4);
    #1;
    checkOutput("jit_near_pulse", 32'(pulses - p0), 1);
    checkOutput("jit_near_x", 32'(bus.tp_x_coord), 110);
    checkOutput("jit_near_y", 32'(bus.tp_y_coord), 110);
    releaseFinger();
    p0 = pulses;
    applyStimulus(1'b1, 1'b1, 110, 110, 1);
    applyStimulus(1'b1, 1'b1, 130, 110, 1);
    applyStimulus(1'b0, 1'b0, 0, 0, 4);
    #1;
    checkOutput("jit_far_wait", 32'(pulses - p0), 0);
    applyStimulus(1'b0, 1'b0, 0, 0, 1);
    #1;
    checkOutput("jit_far_pulse", 32'(pulses - p0), 1);
    checkOutput("jit_far_x", 32'(bus.tp_x_coord), 130);
    releaseFinger();

    // Long hold with a release bounce gives a single tap
    p0 = pulses;
    applyStimulus(1'b1, 1'b1, 400, 300, 100);
    applyStimulus(1'b1, 1'b0, 0, 0, 1);
    applyStimulus(1'b0, 1'b0, 0, 0, 1);
    applyStimulus(1'b1, 1'b1, 400, 300, 1);
    applyStimulus(1'b0, 1'b0, 0, 0, 1);
    #1;
    checkOutput("hold_touching", 32'(bus.touching), 1);
    applyStimulus(1'b1, 1'b0, 0, 0, 4);
    applyStimulus(1'b0, 1'b0, 0, 0, 3);
    #1;
    checkOutput("hold_pulses", 32'(pulses - p0), 1);
    checkOutput("hold_released", 32'(bus.touching), 0);

    // Off-screen samples, then a stalled driver while pressed
    p0 = pulses;
    applyStimulus(1'b1, 1'b1, 900, 100, 10);
    applyStimulus(1'b0, 1'b0, 0, 0, 2);
    #1;
    checkOutput("offscreen_pulses", 32'(pulses - p0), 0);
    applyStimulus(1'b1, 1'b1, 500, 200, 6);
    #1;
    checkOutput("stale_pressed", 32'(bus.touching), 1);
    applyStimulus(1'b0, 1'b0, 0, 0, 20);
    #1;
    checkOutput("stale_dropped", 32'(bus.touching), 0);

    // Randomized traffic in 50-cycle patterns: quiet, steady, noisy, lifted
    pat = 1; cxr = 100; cyr = 100;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        pat = $urandom_range(0, 3);
        cxr = $urandom_range(0, 900);
        cyr = $urandom_range(0, 520);
      end
      @(negedge clk);
      case (pat)
        0: bus.s_valid = ($urandom_range(0, 31) == 0);
        1: bus.s_valid = ($urandom_range(0, 3) != 0);
        default: bus.s_valid = ($urandom_range(0, 1) == 0);
      endcase
      bus.s_touch = (pat == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 15) != 0);
      bus.s_x = 16'(cxr + ((pat == 2) ? $urandom_range(0, 24) : $urandom_range(0, 6)));
      bus.s_y = 16'(cyr + ((pat == 2) ? $urandom_range(0, 24) : $urandom_range(0, 6)));
      if ($urandom_range(0, 999) == 0) begin
        #2 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    applyStimulus(1'b0, 1'b0, 0, 0, 4);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
